flu_wb_sched: RTL

FLU_WB_SCHED -- requirements
Module: flu_wb_sched

---
 rtl/flu_wb_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/flu_wb_sched.sv
// FLU writeback scheduler: arbitrates single-cycle, MUL and DIV results onto one port.
// Define FLU_WB_PERF_EN to build the issue-stall cycle counter.
module flu_wb_sched #(
   parameter int unsigned TRANS_ID_BITS = 3,
   parameter int unsigned XLEN          = 64,
   parameter int unsigned MUL_LATENCY   = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     issue_valid_i,
   input  logic [1:0]               issue_fu_i,
   input  logic                     issue_is_div_i,
   input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
   output logic                     issue_ready_o,
   input  logic [XLEN-1:0]          sc_result_i,
   input  logic [XLEN-1:0]          mul_result_i,
   input  logic                     div_done_i,
   input  logic [XLEN-1:0]          div_result_i,
   output logic                     div_start_o,
   output logic                     div_kill_o,
   output logic                     wb_valid_o,
   output logic [1:0]               wb_src_o,
   output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
   output logic [XLEN-1:0]          wb_result_o,
   output logic [31:0]              perf_stall_cnt_o
);

   typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_HOLD} state_t;

   localparam logic [1:0] FU_MDU  = 2'd3;
   localparam logic [1:0] SRC_SC  = 2'd0;
   localparam logic [1:0] SRC_MUL = 2'd1;
   localparam logic [1:0] SRC_DIV = 2'd2;

   state_t state, state_nxt;

   logic [MUL_LATENCY-1:0]                    mul_vld;
   logic [MUL_LATENCY-1:0][TRANS_ID_BITS-1:0] mul_id;
   logic [TRANS_ID_BITS-1:0]                  div_id;
   logic [XLEN-1:0]                           div_buf;

   logic live, mul_tail, mul_empty, done;
   logic is_mdu, is_sc, is_mul, is_div;
   logic sc_ok, mul_ok, div_ok, ready;
   logic mul_acc, div_acc;

   assign live      = !rst_i && !flush_i;
   assign mul_tail  = mul_vld[MUL_LATENCY-1];
   assign mul_empty = ~|mul_vld;
   assign done      = div_done_i && (state == DIV_BUSY);

   assign is_mdu = (issue_fu_i == FU_MDU);
   assign is_sc  = issue_valid_i && !is_mdu;
   assign is_mul = issue_valid_i && is_mdu && !issue_is_div_i;
   assign is_div = issue_valid_i && is_mdu && issue_is_div_i;

   // Single-cycle ops only win the port when no older result wants it.
   assign sc_ok  = (state != DIV_HOLD) && !mul_tail && !done;
   assign mul_ok = (state == IDLE);
   assign div_ok = (state == IDLE) && mul_empty;
   assign ready  = live && ((is_sc && sc_ok) || (is_mul && mul_ok) ||
                            (is_div && div_ok));

   assign issue_ready_o = ready;
   assign mul_acc       = ready && is_mul;
   assign div_acc       = ready && is_div;
   assign div_start_o   = div_acc;
   assign div_kill_o    = !rst_i && flush_i && (state == DIV_BUSY);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (div_acc) state_nxt = DIV_BUSY;
         DIV_BUSY: if (done) state_nxt = mul_tail ? DIV_HOLD : IDLE;
         DIV_HOLD: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   always_comb begin
      wb_valid_o    = 1'b0;
      wb_src_o      = SRC_SC;
      wb_trans_id_o = '0;
      wb_result_o   = '0;
      if (live) begin
         if (state == DIV_HOLD) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SRC_DIV;
            wb_trans_id_o = div_id;
            wb_result_o   = div_buf;
         end else if (mul_tail) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SRC_MUL;
            wb_trans_id_o = mul_id[MUL_LATENCY-1];
            wb_result_o   = mul_result_i;
         end else if (done) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SRC_DIV;
            wb_trans_id_o = div_id;
            wb_result_o   = div_result_i;
         end else if (ready && is_sc) begin
            wb_valid_o    = 1'b1;
            wb_src_o      = SRC_SC;
            wb_trans_id_o = issue_trans_id_i;
            wb_result_o   = sc_result_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         mul_vld <= '0;
         mul_id  <= '0;
         div_buf <= '0;
         div_id  <= '0;
      end else begin
         for (int i = MUL_LATENCY - 1; i > 0; i--) begin
            mul_vld[i] <= mul_vld[i-1];
            mul_id[i]  <= mul_id[i-1];
         end
         mul_vld[0] <= mul_acc;
         mul_id[0]  <= mul_acc ? issue_trans_id_i : '0;
         if (div_acc) div_id <= issue_trans_id_i;
         // Divider finished under a MUL tail: park it for next cycle.
         if (done && mul_tail) div_buf <= div_result_i;
      end
   end

`ifdef FLU_WB_PERF_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (issue_valid_i && !ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt_o = stall_cnt;
`else
   assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
